// File: rtl/hdmi_info_frame_pkg.sv
// Shared InfoFrame receiver types: AVI header constants, decoded field
// bundle, bar bundle and the receive FSM state.
package hdmi_info_frame_pkg;

  localparam logic [7:0] AVI_TYPE    = 8'h82;
  localparam logic [7:0] AVI_VERSION = 8'd2;
  localparam logic [4:0] AVI_LENGTH  = 5'd13;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT
  } info_frame_state_t;

  // MSB-first order matches {PB1[6:0], PB2, PB3, PB4[6:0], PB5}
  typedef struct packed {
    logic [1:0] video_format;
    logic       afi_present;
    logic [1:0] bar_info;
    logic [1:0] scan_info;
    logic [1:0] colorimetry;
    logic [1:0] aspect_ratio;
    logic [3:0] afar;
    logic       it_content;
    logic [2:0] ext_colorimetry;
    logic [1:0] rgb_quant;
    logic [1:0] nups;
    logic [6:0] vic;
    logic [1:0] ycc_quant;
    logic [1:0] content_type;
    logic [3:0] pixel_rep;
  } avi_fields_t;

  typedef struct packed {
    logic [15:0] top_end;
    logic [15:0] bottom_start;
    logic [15:0] left_end;
    logic [15:0] right_start;
  } avi_bars_t;

  function automatic logic avi_header_ok(
    input logic [23:0] hdr,
    input bit          exact_version
  );
    logic ver_ok;
    ver_ok = exact_version ? (hdr[15:8] == AVI_VERSION)
                           : (hdr[15:8] >= AVI_VERSION);
    return (hdr[7:0] == AVI_TYPE) && ver_ok &&
           (hdr[20:16] == AVI_LENGTH) && (hdr[23:21] == 3'b000);
  endfunction

  // b[0] is PB6 ... b[7] is PB13, each pair little-endian
  function automatic avi_bars_t avi_bar_decode(
    input logic [7:0][7:0] b
  );
    return avi_bars_t'({b[1], b[0], b[3], b[2],
                        b[5], b[4], b[7], b[6]});
  endfunction

endpackage

// File: rtl/info_frame_checksum_serial.sv
// Byte-serial 8-bit wrapping accumulator for InfoFrame checksums;
// o_zero flags a valid (zero-sum) packet.
module info_frame_checksum_serial (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic       o_zero
);

  logic [7:0] r_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + i_byte;
    end
  end

  assign o_zero = (r_acc == 8'h00);

endmodule

// File: rtl/auxiliary_video_information_info_frame_receiver.sv
// AVI InfoFrame sink: filters AVI packets, checks the checksum serially,
// latches decoded fields. Option: AVI_INFO_FRAME_RECEIVER_BAR_DECODE_EN.
module auxiliary_video_information_info_frame_receiver
  import hdmi_info_frame_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 4,
  parameter bit CHECK_VERSION  = 1'b1
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             packet_valid,
  output logic             packet_ready,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  input  logic             frame_start,
  output logic             avi_valid,
  output logic             avi_updated,
  output logic             checksum_error,
  output logic [1:0]       video_format,
  output logic             active_format_info_present,
  output logic [1:0]       bar_info,
  output logic [1:0]       scan_info,
  output logic [1:0]       colorimetry,
  output logic [1:0]       picture_aspect_ratio,
  output logic [3:0]       active_format_aspect_ratio,
  output logic             it_content,
  output logic [2:0]       extended_colorimetry,
  output logic [1:0]       rgb_quantization_range,
  output logic [1:0]       non_uniform_picture_scaling,
  output logic [6:0]       video_id_code,
  output logic [1:0]       ycc_quantization_range,
  output logic [1:0]       content_type,
  output logic [3:0]       pixel_repetition,
  output logic [15:0]      bar_top_end,
  output logic [15:0]      bar_bottom_start,
  output logic [15:0]      bar_left_end,
  output logic [15:0]      bar_right_start
);

  localparam bit TO_EN = (TIMEOUT_FRAMES != 0);
  localparam int FW = TO_EN ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [FW-1:0] FMAX = FW'(TIMEOUT_FRAMES);
  localparam logic [FW-1:0] FPRE =
    FW'(TO_EN ? TIMEOUT_FRAMES - 1 : 0);

  info_frame_state_t r_state;
  logic [4:0]        r_cnt;
  logic [16:0][7:0]  r_buf;
  logic [13:0][7:0]  w_pb;
  avi_fields_t       r_fields;
  avi_fields_t       w_fields;
  logic              r_valid;
  logic              r_updated;
  logic              r_err;
  logic [FW-1:0]     r_frames;
  logic              w_accept;
  logic              w_add;
  logic              w_zero;
  logic              w_commit_good;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic              w_unused;

  for (genvar g = 0; g < 14; g++) begin : g_pb
    assign w_pb[g] = sub[g/7][8*(g%7) +: 8];
  end

  assign w_unused = &{1'b0, sub[3:2]};

  assign w_accept = packet_valid && (r_state == IDLE) &&
                    avi_header_ok(header, CHECK_VERSION);
  assign w_add    = (r_state == CHECK);
  assign w_byte   = r_buf[r_cnt];

  // r_buf[0..2] = header bytes, r_buf[n+3] = PBn
  assign w_fields = avi_fields_t'({r_buf[4][6:0], r_buf[5],
                                   r_buf[6], r_buf[7][6:0],
                                   r_buf[8]});

  assign w_commit_good = (r_state == COMMIT) && w_zero;
  assign w_timeout     = TO_EN && frame_start && (r_frames >= FPRE);

  info_frame_checksum_serial u_csum (
    .i_clk   (clk_pixel),
    .i_rst   (reset),
    .i_clear (w_accept),
    .i_add   (w_add),
    .i_byte  (w_byte),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_updated <= 1'b0;
      r_err     <= 1'b0;
      r_fields  <= '0;
      r_frames  <= '0;
    end else begin
      r_updated <= 1'b0;
      r_err     <= 1'b0;

      // Commit has priority over the frame timeout
      if (w_commit_good) begin
        r_frames <= '0;
      end else if (TO_EN && frame_start && r_frames != FMAX) begin
        r_frames <= r_frames + 1'b1;
      end

      if (w_commit_good) begin
        r_fields <= w_fields;
        r_valid  <= 1'b1;
      end else if (w_timeout) begin
        r_fields <= '0;
        r_valid  <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_buf   <= {w_pb, header};
            r_cnt   <= '0;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd16) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_state <= IDLE;
          if (w_zero) begin
            r_updated <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign packet_ready   = (r_state == IDLE);
  assign avi_valid      = r_valid;
  assign avi_updated    = r_updated;
  assign checksum_error = r_err;

  assign video_format                = r_fields.video_format;
  assign active_format_info_present  = r_fields.afi_present;
  assign bar_info                    = r_fields.bar_info;
  assign scan_info                   = r_fields.scan_info;
  assign colorimetry                 = r_fields.colorimetry;
  assign picture_aspect_ratio        = r_fields.aspect_ratio;
  assign active_format_aspect_ratio  = r_fields.afar;
  assign it_content                  = r_fields.it_content;
  assign extended_colorimetry        = r_fields.ext_colorimetry;
  assign rgb_quantization_range      = r_fields.rgb_quant;
  assign non_uniform_picture_scaling = r_fields.nups;
  assign video_id_code               = r_fields.vic;
  assign ycc_quantization_range      = r_fields.ycc_quant;
  assign content_type                = r_fields.content_type;
  assign pixel_repetition            = r_fields.pixel_rep;

`ifdef AVI_INFO_FRAME_RECEIVER_BAR_DECODE_EN
  avi_bars_t r_bars;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_bars <= '0;
    end else if (w_commit_good) begin
      r_bars <= (w_fields.bar_info != 2'b00)
                ? avi_bar_decode(r_buf[16:9]) : '0;
    end else if (w_timeout) begin
      r_bars <= '0;
    end
  end

  assign bar_top_end      = r_bars.top_end;
  assign bar_bottom_start = r_bars.bottom_start;
  assign bar_left_end     = r_bars.left_end;
  assign bar_right_start  = r_bars.right_start;
`else
  assign bar_top_end      = '0;
  assign bar_bottom_start = '0;
  assign bar_left_end     = '0;
  assign bar_right_start  = '0;
`endif

endmodule

// File: tb/tb_auxiliary_video_information_info_frame_receiver.sv
// Self-checking bench for the AVI InfoFrame receiver: vector table,
// hand-written timing sequences and random packets against a model.
module tb_auxiliary_video_information_info_frame_receiver;

  localparam int T_FRAMES = 4;
`ifdef AVI_INFO_FRAME_RECEIVER_BAR_DECODE_EN
  localparam bit BAR_EN = 1'b1;
`else
  localparam bit BAR_EN = 1'b0;
`endif

  typedef logic [7:0] pb_t [28];

  typedef struct {
    logic [23:0] hdr;
    logic [7:0]  pb0;
    logic [7:0]  pb1;
    logic [7:0]  pb2;
    logic [7:0]  pb4;
    bit          upd;
    bit          err;
    bit          valid;
    logic [6:0]  vic;
  } vec_t;

  logic             clk_pixel = 1'b0;
  logic             reset;
  logic             packet_valid;
  logic             packet_ready;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic             frame_start;
  logic             avi_valid;
  logic             avi_updated;
  logic             checksum_error;
  logic [1:0]       video_format;
  logic             active_format_info_present;
  logic [1:0]       bar_info;
  logic [1:0]       scan_info;
  logic [1:0]       colorimetry;
  logic [1:0]       picture_aspect_ratio;
  logic [3:0]       active_format_aspect_ratio;
  logic             it_content;
  logic [2:0]       extended_colorimetry;
  logic [1:0]       rgb_quantization_range;
  logic [1:0]       non_uniform_picture_scaling;
  logic [6:0]       video_id_code;
  logic [1:0]       ycc_quantization_range;
  logic [1:0]       content_type;
  logic [3:0]       pixel_repetition;
  logic [15:0]      bar_top_end;
  logic [15:0]      bar_bottom_start;
  logic [15:0]      bar_left_end;
  logic [15:0]      bar_right_start;

  always #5 clk_pixel = ~clk_pixel;

  auxiliary_video_information_info_frame_receiver #(
    .TIMEOUT_FRAMES (T_FRAMES),
    .CHECK_VERSION  (1'b1)
  ) dut (
    .clk_pixel                   (clk_pixel),
    .reset                       (reset),
    .packet_valid                (packet_valid),
    .packet_ready                (packet_ready),
    .header                      (header),
    .sub                         (sub),
    .frame_start                 (frame_start),
    .avi_valid                   (avi_valid),
    .avi_updated                 (avi_updated),
    .checksum_error              (checksum_error),
    .video_format                (video_format),
    .active_format_info_present  (active_format_info_present),
    .bar_info                    (bar_info),
    .scan_info                   (scan_info),
    .colorimetry                 (colorimetry),
    .picture_aspect_ratio        (picture_aspect_ratio),
    .active_format_aspect_ratio  (active_format_aspect_ratio),
    .it_content                  (it_content),
    .extended_colorimetry        (extended_colorimetry),
    .rgb_quantization_range      (rgb_quantization_range),
    .non_uniform_picture_scaling (non_uniform_picture_scaling),
    .video_id_code               (video_id_code),
    .ycc_quantization_range      (ycc_quantization_range),
    .content_type                (content_type),
    .pixel_repetition            (pixel_repetition),
    .bar_top_end                 (bar_top_end),
    .bar_bottom_start            (bar_bottom_start),
    .bar_left_end                (bar_left_end),
    .bar_right_start             (bar_right_start)
  );

  logic [37:0] dut_fields;
  logic [63:0] dut_bars;

  assign dut_fields = {video_format, active_format_info_present,
                       bar_info, scan_info, colorimetry,
                       picture_aspect_ratio,
                       active_format_aspect_ratio, it_content,
                       extended_colorimetry, rgb_quantization_range,
                       non_uniform_picture_scaling, video_id_code,
                       ycc_quantization_range, content_type,
                       pixel_repetition};
  assign dut_bars = {bar_top_end, bar_bottom_start,
                     bar_left_end, bar_right_start};

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid;
  logic [37:0] m_fields;
  logic [63:0] m_bars;
  int          m_frames;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_is_avi(input logic [23:0] hdr);
    return hdr[7:0] == 8'h82 && hdr[15:8] == 8'd2 &&
           hdr[23:16] == 8'd13;
  endfunction

  function automatic int ref_sum(input logic [23:0] hdr,
                                 input pb_t pb, input bit skip0);
    int s;
    s = int'(hdr[7:0]) + int'(hdr[15:8]) + int'(hdr[23:16]);
    for (int i = (skip0 ? 1 : 0); i < 14; i++) s += int'(pb[i]);
    return s % 256;
  endfunction

  function automatic logic [37:0] ref_fields(input pb_t pb);
    return {pb[1][6:0], pb[2], pb[3], pb[4][6:0], pb[5]};
  endfunction

  function automatic logic [63:0] ref_bars(input pb_t pb);
    logic [63:0] b;
    b = {pb[7], pb[6], pb[9], pb[8], pb[11], pb[10], pb[13], pb[12]};
    return (BAR_EN && pb[1][3:2] != 2'b00) ? b : 64'd0;
  endfunction

  function automatic logic [3:0][55:0] pack_sub(input pb_t pb);
    logic [3:0][55:0] s;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 7; k++) s[i][8*k +: 8] = pb[7*i+k];
    return s;
  endfunction

  function automatic void fix_pb0(input logic [23:0] hdr,
                                  inout pb_t pb);
    pb[0] = 8'(256 - ref_sum(hdr, pb, 1'b1));
  endfunction

  function automatic void model_tick();
    if (T_FRAMES != 0) begin
      if (m_frames < T_FRAMES) m_frames++;
      if (m_frames == T_FRAMES) begin
        m_valid  = 1'b0;
        m_fields = '0;
        m_bars   = '0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_valid  = 1'b0;
    m_fields = '0;
    m_bars   = '0;
    m_frames = 0;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 64'(avi_valid), 64'(m_valid));
    check({tag, "_fields"}, 64'(dut_fields), 64'(m_fields));
    check({tag, "_bars"}, dut_bars, m_bars);
  endtask

  task automatic frame_tick();
    frame_start = 1'b1;
    @(negedge clk_pixel);
    frame_start = 1'b0;
    model_tick();
    check_state("frame");
  endtask

  task automatic send(input logic [23:0] hdr, input pb_t pb,
                      input bit fs_commit,
                      output bit o_upd, output bit o_err);
    int  w;
    bit  avi;
    bit  good;
    w = 0;
    while (packet_ready !== 1'b1 && w < 64) begin
      @(negedge clk_pixel);
      w++;
    end
    check("ready_before_send", 64'(packet_ready), 64'd1);
    avi  = ref_is_avi(hdr);
    good = avi && ref_sum(hdr, pb, 1'b0) == 0;
    header       = hdr;
    sub          = pack_sub(pb);
    packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    header       = 24'($urandom());
    for (int i = 0; i < 4; i++)
      sub[i] = 56'({$urandom(), $urandom()});
    if (!avi) begin
      o_upd = avi_updated;
      o_err = checksum_error;
      check("ignored_ready", 64'(packet_ready), 64'd1);
      check_state("ignored");
      return;
    end
    check("busy_ready", 64'(packet_ready), 64'd0);
    repeat (17) @(negedge clk_pixel);
    check("early_pulse", 64'({avi_updated, checksum_error}), 64'd0);
    check("busy_ready_end", 64'(packet_ready), 64'd0);
    frame_start = fs_commit;
    @(negedge clk_pixel);
    frame_start = 1'b0;
    if (good) begin
      m_fields = ref_fields(pb);
      m_bars   = ref_bars(pb);
      m_valid  = 1'b1;
      m_frames = 0;
    end else if (fs_commit) begin
      model_tick();
    end
    o_upd = avi_updated;
    o_err = checksum_error;
    check("commit_upd", 64'(avi_updated), 64'(good));
    check("commit_err", 64'(checksum_error), 64'(!good));
    check("ready_after", 64'(packet_ready), 64'd1);
    check_state("commit");
    @(negedge clk_pixel);
    check("pulse_width", 64'({avi_updated, checksum_error}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    pb_t         pb;
    logic [23:0] hdr;
    bit          upd;
    bit          err;
    bit          saw;
    int          kind;

    vecs[0] = '{24'h0D0282, 8'h63, 8'h00, 8'h08, 8'h04,
                1'b1, 1'b0, 1'b1, 7'd4};
    vecs[1] = '{24'h0D0282, 8'h64, 8'h00, 8'h08, 8'h04,
                1'b0, 1'b1, 1'b1, 7'd4};
    vecs[2] = '{24'h0A0184, 8'h00, 8'h00, 8'h00, 8'h00,
                1'b0, 1'b0, 1'b1, 7'd4};
    vecs[3] = '{24'h0D0382, 8'h62, 8'h00, 8'h08, 8'h04,
                1'b0, 1'b0, 1'b1, 7'd4};
    vecs[4] = '{24'h2D0282, 8'h63, 8'h00, 8'h08, 8'h04,
                1'b0, 1'b0, 1'b1, 7'd4};
    vecs[5] = '{24'h0D0282, 8'h57, 8'h00, 8'h08, 8'h10,
                1'b1, 1'b0, 1'b1, 7'd16};
    vecs[6] = '{24'h0D0281, 8'h64, 8'h00, 8'h08, 8'h04,
                1'b0, 1'b0, 1'b1, 7'd16};

    reset        = 1'b1;
    packet_valid = 1'b0;
    frame_start  = 1'b0;
    header       = '0;
    sub          = '0;
    model_reset();
    repeat (3) @(negedge clk_pixel);
    reset = 1'b0;
    check("reset_ready", 64'(packet_ready), 64'd1);
    check("reset_pulses", 64'({avi_updated, checksum_error}), 64'd0);
    check_state("reset");

    foreach (vecs[i]) begin
      foreach (pb[j]) pb[j] = (j >= 14) ? 8'($urandom()) : 8'h00;
      pb[0] = vecs[i].pb0;
      pb[1] = vecs[i].pb1;
      pb[2] = vecs[i].pb2;
      pb[4] = vecs[i].pb4;
      send(vecs[i].hdr, pb, 1'b0, upd, err);
      check($sformatf("vec%0d_upd", i), 64'(upd), 64'(vecs[i].upd));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
      check($sformatf("vec%0d_valid", i), 64'(avi_valid),
            64'(vecs[i].valid));
      check($sformatf("vec%0d_vic", i), 64'(video_id_code),
            64'(vecs[i].vic));
    end

    repeat (3) begin
      frame_tick();
      check("to_hold_valid", 64'(avi_valid), 64'd1);
    end
    frame_tick();
    check("to_drop_valid", 64'(avi_valid), 64'd0);
    check("to_drop_vic", 64'(video_id_code), 64'd0);

    foreach (pb[j]) pb[j] = 8'h00;
    pb[0] = 8'h63; pb[2] = 8'h08; pb[4] = 8'h04;
    send(24'h0D0282, pb, 1'b0, upd, err);
    repeat (3) frame_tick();
    send(24'h0D0282, pb, 1'b1, upd, err);
    check("fs_commit_upd", 64'(upd), 64'd1);
    check("fs_commit_valid", 64'(avi_valid), 64'd1);
    repeat (3) frame_tick();
    check("fs_commit_cnt_reset", 64'(avi_valid), 64'd1);
    frame_tick();
    check("fs_commit_then_drop", 64'(avi_valid), 64'd0);

    send(24'h0D0282, pb, 1'b0, upd, err);
    repeat (3) frame_tick();
    pb[0] = 8'h64;
    send(24'h0D0282, pb, 1'b1, upd, err);
    check("err_to_pulse", 64'(err), 64'd1);
    check("err_to_valid", 64'(avi_valid), 64'd0);
    check("err_to_vic", 64'(video_id_code), 64'd0);

    foreach (pb[j]) pb[j] = 8'h00;
    pb[1] = 8'h0C;
    pb[6] = 8'hFF; pb[7] = 8'hFF; pb[10] = 8'hFF; pb[11] = 8'hFF;
    fix_pb0(24'h0D0282, pb);
    send(24'h0D0282, pb, 1'b0, upd, err);
    check("bar_upd", 64'(upd), 64'd1);
    check("bar_values", dut_bars,
          BAR_EN ? 64'hFFFF_0000_FFFF_0000 : 64'd0);
    pb[1] = 8'h00;
    fix_pb0(24'h0D0282, pb);
    send(24'h0D0282, pb, 1'b0, upd, err);
    check("bar_info0_values", dut_bars, 64'd0);

    foreach (pb[j]) pb[j] = 8'h00;
    pb[0] = 8'h63; pb[2] = 8'h08; pb[4] = 8'h04;
    header       = 24'h0D0282;
    sub          = pack_sub(pb);
    packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    repeat (4) @(negedge clk_pixel);
    reset = 1'b1;
    @(negedge clk_pixel);
    reset = 1'b0;
    model_reset();
    check("rst_mid_ready0", 64'(packet_ready), 64'd1);
    @(negedge clk_pixel);
    check("rst_mid_ready1", 64'(packet_ready), 64'd1);
    check_state("rst_mid");
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk_pixel);
      if (avi_updated || checksum_error) saw = 1'b1;
    end
    check("rst_mid_no_pulse", 64'(saw), 64'd0);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) frame_tick();
      foreach (pb[j]) pb[j] = 8'($urandom());
      kind = $urandom_range(0, 4);
      hdr  = 24'h0D0282;
      if (kind == 3) begin
        hdr[7:0] = 8'($urandom());
        if (hdr[7:0] == 8'h82) hdr[7:0] = 8'h83;
      end else if (kind == 4) begin
        hdr[15:8] = 8'($urandom_range(3, 255));
      end
      fix_pb0(hdr, pb);
      if (kind == 2) begin
        int idx;
        idx = $urandom_range(0, 13);
        pb[idx] = pb[idx] ^ 8'($urandom_range(1, 255));
      end
      send(hdr, pb, ($urandom_range(0, 3) == 0), upd, err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
